// File: rtl/body_box_if.sv
// Segment-stream bundle between the body_box_sequencer (master) and its
// consumers: joint-tracking inputs, the line drawer handshake and status.
interface body_box_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          start;
  logic [XW-1:0] hcx, lcx, rcx;
  logic [YW-1:0] hcy, lcy, rcy;
  logic          seg_valid;
  logic          seg_ready;
  logic [XW-1:0] seg_x1, seg_x2;
  logic [YW-1:0] seg_y1, seg_y2;
  logic [5:0]    seg_idx;
  logic          seg_erase;
  logic          busy;
  logic          done;

  modport master (
    input  start, hcx, lcx, rcx, hcy, lcy, rcy, seg_ready,
    output seg_valid, seg_x1, seg_x2, seg_y1, seg_y2, seg_idx, seg_erase,
           busy, done
  );

  modport slave (
    output start, hcx, lcx, rcx, hcy, lcy, rcy, seg_ready,
    input  seg_valid, seg_x1, seg_x2, seg_y1, seg_y2, seg_idx, seg_erase,
           busy, done
  );
endinterface

// File: rtl/body_box_sequencer.sv
// Streams the 48 wireframe segments of a four-box body model to the line
// drawer, optionally preceded by an erase pass of the previous frame.
// Geometry is computed signed with two guard bits and clamped per endpoint.
module body_box_sequencer #(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int DEPTH_SHIFT = 3,
  parameter int DX0         = 40,
  parameter int DY0         = 10,
  parameter int ERASE_EN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  body_box_if.master bus
);

  typedef logic signed [XW+1:0] sx_t;
  typedef logic signed [YW+1:0] sy_t;

  localparam sx_t XMAX = sx_t'(SCREEN_W - 1);
  localparam sy_t YMAX = sy_t'(SCREEN_H - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ERASE, DRAW, FINISH} state_t;

  state_t state, state_nxt;

  // Snapshots of the joint anchors: new is the frame being drawn, old the
  // frame currently on screen (erased first when have_old is set).
  logic [XW-1:0] new_hx, new_lx, new_rx, old_hx, old_lx, old_rx;
  logic [YW-1:0] new_hy, new_ly, new_ry, old_hy, old_ly, old_ry;
  logic          have_old;

  // Per-cycle control decoded from the state
  logic          hs, last, erase_pass;
  logic          ld, ld_old, ld_erase, vld_nxt, capture, commit;
  logic [5:0]    ld_idx;

  // Geometry of the segment selected by ld_idx / ld_old
  logic [XW-1:0] src_hx, src_lx, src_rx, ax;
  logic [YW-1:0] src_hy, src_ly, src_ry, ay;
  logic [1:0]    box, ca, cb;
  logic [3:0]    j;
  logic          ba, bb;
  sx_t           hw, l, r, dx, x_a, x_b;
  sy_t           t_off, b_off, tp, bt, dy, y_a, y_b;

  function automatic logic [XW-1:0] clamp_x(input sx_t v);
    if (v[XW+1])    return '0;
    else if (v > XMAX) return XMAX[XW-1:0];
    else            return v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input sy_t v);
    if (v[YW+1])    return '0;
    else if (v > YMAX) return YMAX[YW-1:0];
    else            return v[YW-1:0];
  endfunction

  assign hs         = bus.seg_valid & bus.seg_ready;
  assign last       = (bus.seg_idx == 6'd47);
  assign erase_pass = (ERASE_EN != 0) && have_old;

  // State register; reset returns to IDLE at once, abandoning any pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = erase_pass ? ERASE : DRAW;
      ERASE:   if (hs && last) state_nxt = DRAW;
      DRAW:    if (hs && last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath-control decode; the ERASE->DRAW hand-over loads new
  // segment 0 on the last erase handshake so the stream has no bubble
  always_comb begin
    ld       = 1'b0;
    ld_idx   = '0;
    ld_old   = 1'b0;
    ld_erase = 1'b0;
    vld_nxt  = bus.seg_valid;
    capture  = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: capture = bus.start;
      LOAD: begin
        ld       = 1'b1;
        ld_old   = erase_pass;
        ld_erase = erase_pass;
        vld_nxt  = 1'b1;
      end
      ERASE: begin
        if (hs) begin
          ld = 1'b1;
          if (!last) begin
            ld_idx   = bus.seg_idx + 6'd1;
            ld_old   = 1'b1;
            ld_erase = 1'b1;
          end
        end
      end
      DRAW: begin
        if (hs) begin
          if (last) begin
            vld_nxt = 1'b0;
            commit  = 1'b1;
          end else begin
            ld     = 1'b1;
            ld_idx = bus.seg_idx + 6'd1;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == FINISH);

  // Segment geometry: pick box anchor and shape, then the two corners of
  // edge j (front ring, back ring, or front-to-back connector)
  always_comb begin
    src_hx = ld_old ? old_hx : new_hx;
    src_hy = ld_old ? old_hy : new_hy;
    src_lx = ld_old ? old_lx : new_lx;
    src_ly = ld_old ? old_ly : new_ly;
    src_rx = ld_old ? old_rx : new_rx;
    src_ry = ld_old ? old_ry : new_ry;

    box = 2'(ld_idx / 6'd12);
    j   = 4'(ld_idx % 6'd12);

    case (box)
      2'd0, 2'd1: begin ax = src_hx; ay = src_hy; end
      2'd2:       begin ax = src_lx; ay = src_ly; end
      default:    begin ax = src_rx; ay = src_ry; end
    endcase

    case (box)
      2'd0:    begin hw = sx_t'(50); t_off = sy_t'(-10); b_off = sy_t'(90);  end
      2'd1:    begin hw = sx_t'(40); t_off = sy_t'(110); b_off = sy_t'(230); end
      default: begin hw = sx_t'(20); t_off = sy_t'(0);   b_off = sy_t'(60);  end
    endcase

    l  = $signed({2'b00, ax}) - hw;
    r  = $signed({2'b00, ax}) + hw;
    tp = $signed({2'b00, ay}) + t_off;
    bt = $signed({2'b00, ay}) + b_off;
    dx = $signed({2'b00, ax >> DEPTH_SHIFT}) - sx_t'(DX0);
    dy = $signed({2'b00, ay >> DEPTH_SHIFT}) - sy_t'(DY0);

    // Corners numbered TL=0, TR=1, BR=2, BL=3; ba/bb select the back face
    if (j[3]) begin
      ca = j[1:0];
      cb = j[1:0];
      ba = 1'b0;
      bb = 1'b1;
    end else begin
      ca = j[1:0];
      cb = j[1:0] + 2'd1;
      ba = j[2];
      bb = j[2];
    end

    x_a = (((ca == 2'd0) || (ca == 2'd3)) ? l : r) + (ba ? dx : sx_t'(0));
    x_b = (((cb == 2'd0) || (cb == 2'd3)) ? l : r) + (bb ? dx : sx_t'(0));
    y_a = ((ca[1] == 1'b0) ? tp : bt) + (ba ? dy : sy_t'(0));
    y_b = ((cb[1] == 1'b0) ? tp : bt) + (bb ? dy : sy_t'(0));
  end

  // Output registers and have_old; everything visible clears on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.seg_valid <= 1'b0;
      bus.seg_idx   <= '0;
      bus.seg_erase <= 1'b0;
      bus.seg_x1    <= '0;
      bus.seg_y1    <= '0;
      bus.seg_x2    <= '0;
      bus.seg_y2    <= '0;
      have_old      <= 1'b0;
    end else begin
      bus.seg_valid <= vld_nxt;
      if (ld) begin
        bus.seg_idx   <= ld_idx;
        bus.seg_erase <= ld_erase;
        bus.seg_x1    <= clamp_x(x_a);
        bus.seg_y1    <= clamp_y(y_a);
        bus.seg_x2    <= clamp_x(x_b);
        bus.seg_y2    <= clamp_y(y_b);
      end
      if (commit) have_old <= 1'b1;
    end
  end

  // Anchor snapshots: captured on an accepted start, promoted after a frame
  always_ff @(posedge clk) begin
    if (capture) begin
      new_hx <= bus.hcx;
      new_hy <= bus.hcy;
      new_lx <= bus.lcx;
      new_ly <= bus.lcy;
      new_rx <= bus.rcx;
      new_ry <= bus.rcy;
    end
    if (commit) begin
      old_hx <= new_hx;
      old_hy <= new_hy;
      old_lx <= new_lx;
      old_ly <= new_ly;
      old_rx <= new_rx;
      old_ry <= new_ry;
    end
  end

endmodule

// File: tb/tb_body_box_sequencer.sv
// Testbench for body_box_sequencer: frames driven with directed and random
// anchors and ready patterns, checked against a corner/edge-table model.
module tb_body_box_sequencer;

  localparam int DS   = 3;
  localparam int DX0  = 40;
  localparam int DY0  = 10;
  localparam int SW   = 640;
  localparam int SH   = 480;

  localparam int HWT[4] = '{50, 40, 20, 20};
  localparam int TOP[4] = '{-10, 110, 0, 0};
  localparam int BOT[4] = '{90, 230, 60, 60};
  localparam int EA[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
  localparam int EB[12] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};

  logic clk = 1'b0;
  logic reset;

  body_box_if #(.XW(10), .YW(9)) bus ();

  body_box_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference-model memory of what the design should have captured
  int m_have_old = 0;
  int n_hx, n_hy, n_lx, n_ly, n_rx, n_ry;
  int o_hx, o_hy, o_lx, o_ly, o_rx, o_ry;

  // Accepted segments of the most recent frame
  int rec_x1[96], rec_y1[96], rec_x2[96], rec_y2[96], rec_er[96];

  function automatic int clampi(input int v, input int lim);
    if (v < 0)        return 0;
    else if (v > lim - 1) return lim - 1;
    else              return v;
  endfunction

  function automatic void model_seg(input int hx, hy, lx, ly, rx, ry, input int i,
                                    output int x1, y1, x2, y2);
    int px[8];
    int py[8];
    int k, e, ax, ay, dx, dy;
    k  = i / 12;
    e  = i % 12;
    ax = (k < 2) ? hx : ((k == 2) ? lx : rx);
    ay = (k < 2) ? hy : ((k == 2) ? ly : ry);
    dx = (ax >> DS) - DX0;
    dy = (ay >> DS) - DY0;
    px[0] = ax - HWT[k]; px[1] = ax + HWT[k]; px[2] = px[1]; px[3] = px[0];
    py[0] = ay + TOP[k]; py[1] = py[0]; py[2] = ay + BOT[k]; py[3] = py[2];
    for (int c = 0; c < 4; c++) begin
      px[c+4] = px[c] + dx;
      py[c+4] = py[c] + dy;
    end
    x1 = clampi(px[EA[e]], SW);
    y1 = clampi(py[EA[e]], SH);
    x2 = clampi(px[EB[e]], SW);
    y2 = clampi(py[EB[e]], SH);
  endfunction

  // Runs one frame: pulses start, consumes the stream, checks every
  // presented segment and the done/busy tail. abort_at >= 0 asserts reset
  // when DRAW presents that index.
  task automatic run_frame(input int hx, hy, lx, ly, rx, ry,
                           input int rnd_ready, input int stall7, input int inject,
                           input int abort_at, output int n);
    int total, k, cyc, stall_cnt, idx, injected;
    int ex1, ey1, ex2, ey2, eer;
    bit rdy, er_pass, broke;
    er_pass  = (m_have_old != 0);
    total    = er_pass ? 96 : 48;
    k        = 0;
    cyc      = 0;
    stall_cnt = 0;
    injected = 0;
    broke    = 1'b0;
    n        = 0;

    @(negedge clk);
    bus.hcx = 10'(hx); bus.hcy = 9'(hy);
    bus.lcx = 10'(lx); bus.lcy = 9'(ly);
    bus.rcx = 10'(rx); bus.rcy = 9'(ry);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_hx = hx; n_hy = hy; n_lx = lx; n_ly = ly; n_rx = rx; n_ry = ry;
    // Inputs wander after the snapshot; the frame must not follow them
    bus.hcx = 10'($urandom); bus.hcy = 9'($urandom);
    bus.lcx = 10'($urandom); bus.lcy = 9'($urandom);
    bus.rcx = 10'($urandom); bus.rcy = 9'($urandom);

    checks++;
    if (bus.busy !== 1'b1 || bus.seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_latency busy=%b valid=%b required busy=1 valid=0",
               bus.busy, bus.seg_valid);
    end

    while (k < total && cyc < 3000 && !broke) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      checks++;
      if (bus.seg_valid !== 1'b1) begin
        errors++;
        $display("FAIL seg_valid k=%0d got %b required 1", k, bus.seg_valid);
        broke = 1'b1;
      end else begin
        idx = k % 48;
        eer = (er_pass && k < 48) ? 1 : 0;
        if (eer != 0) model_seg(o_hx, o_hy, o_lx, o_ly, o_rx, o_ry, idx, ex1, ey1, ex2, ey2);
        else          model_seg(n_hx, n_hy, n_lx, n_ly, n_rx, n_ry, idx, ex1, ey1, ex2, ey2);
        checks++;
        if (bus.seg_erase !== 1'(eer) || bus.seg_idx !== 6'(idx) ||
            bus.seg_x1 !== 10'(ex1) || bus.seg_y1 !== 9'(ey1) ||
            bus.seg_x2 !== 10'(ex2) || bus.seg_y2 !== 9'(ey2)) begin
          errors++;
          $display("FAIL segment k=%0d got er=%0d idx=%0d (%0d,%0d)->(%0d,%0d) required er=%0d idx=%0d (%0d,%0d)->(%0d,%0d)",
                   k, bus.seg_erase, bus.seg_idx, bus.seg_x1, bus.seg_y1, bus.seg_x2, bus.seg_y2,
                   eer, idx, ex1, ey1, ex2, ey2);
        end
        if (abort_at == idx && eer == 0) begin
          reset = 1'b1;
          #1;
          checks++;
          if ({bus.seg_valid, bus.busy, bus.done, bus.seg_erase, bus.seg_idx,
               bus.seg_x1, bus.seg_y1, bus.seg_x2, bus.seg_y2} !== 48'd0) begin
            errors++;
            $display("FAIL reset_midpass valid=%b busy=%b done=%b idx=%0d x1=%0d y1=%0d x2=%0d y2=%0d required all 0",
                     bus.seg_valid, bus.busy, bus.done, bus.seg_idx,
                     bus.seg_x1, bus.seg_y1, bus.seg_x2, bus.seg_y2);
          end
          @(negedge clk);
          reset = 1'b0;
          m_have_old = 0;
          n = k;
          return;
        end
        rdy = 1'b1;
        if (rnd_ready != 0) rdy = ($urandom_range(0, 3) != 0);
        if (stall7 != 0 && idx == 7 && stall_cnt < 5) begin
          rdy = 1'b0;
          stall_cnt++;
        end
        bus.seg_ready = rdy;
        if (rdy) begin
          rec_x1[k] = int'(bus.seg_x1);
          rec_y1[k] = int'(bus.seg_y1);
          rec_x2[k] = int'(bus.seg_x2);
          rec_y2[k] = int'(bus.seg_y2);
          rec_er[k] = int'(bus.seg_erase);
          k++;
        end
        if (inject != 0 && k == 10 && injected == 0) begin
          bus.start = 1'b1;
          injected  = 1;
        end
      end
    end
    n = k;
    if (cyc >= 3000) begin
      errors++;
      $display("FAIL frame_timeout accepted=%0d required %0d", k, total);
    end

    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b valid=%b required done=1 busy=1 valid=0",
               bus.done, bus.busy, bus.seg_valid);
    end
    o_hx = n_hx; o_hy = n_hy; o_lx = n_lx; o_ly = n_ly; o_rx = n_rx; o_ry = n_ry;
    m_have_old = 1;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.seg_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_tail done=%b busy=%b valid=%b required all 0",
               bus.done, bus.busy, bus.seg_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.seg_ready = 1'b0;
    bus.hcx = '0; bus.hcy = '0; bus.lcx = '0; bus.lcy = '0; bus.rcx = '0; bus.rcy = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.seg_valid, bus.busy, bus.done, bus.seg_erase, bus.seg_idx,
         bus.seg_x1, bus.seg_y1, bus.seg_x2, bus.seg_y2} !== 48'd0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b done=%b idx=%0d x1=%0d required all 0",
               bus.seg_valid, bus.busy, bus.done, bus.seg_idx, bus.seg_x1);
    end
    reset = 1'b0;
    m_have_old = 0;
    @(negedge clk);
  endtask

  task automatic test_first_frame();
    int n;
    run_frame(320, 100, 200, 300, 440, 300, 0, 0, 0, -1, n);
    checks++;
    if (n != 48 || rec_er[0] != 0 || rec_er[47] != 0) begin
      errors++;
      $display("FAIL first_count got n=%0d er0=%0d er47=%0d required 48 0 0", n, rec_er[0], rec_er[47]);
    end
    checks++;
    if (rec_x1[0] != 270 || rec_y1[0] != 90 || rec_x2[0] != 370 || rec_y2[0] != 90) begin
      errors++;
      $display("FAIL first_seg0 got (%0d,%0d)->(%0d,%0d) required (270,90)->(370,90)",
               rec_x1[0], rec_y1[0], rec_x2[0], rec_y2[0]);
    end
    checks++;
    if (rec_x1[4] != 270 || rec_y1[4] != 92 || rec_x2[4] != 370 || rec_y2[4] != 92) begin
      errors++;
      $display("FAIL first_seg4 got (%0d,%0d)->(%0d,%0d) required (270,92)->(370,92)",
               rec_x1[4], rec_y1[4], rec_x2[4], rec_y2[4]);
    end
    checks++;
    if (rec_x1[24] != 180 || rec_y1[24] != 300 || rec_x2[24] != 220 || rec_y2[24] != 300) begin
      errors++;
      $display("FAIL first_seg24 got (%0d,%0d)->(%0d,%0d) required (180,300)->(220,300)",
               rec_x1[24], rec_y1[24], rec_x2[24], rec_y2[24]);
    end
  endtask

  task automatic test_erase_pass();
    int n;
    run_frame(330, 100, 200, 300, 440, 300, 0, 0, 0, -1, n);
    checks++;
    if (n != 96 || rec_er[0] != 1 || rec_er[47] != 1 || rec_er[48] != 0) begin
      errors++;
      $display("FAIL erase_count got n=%0d er0=%0d er47=%0d er48=%0d required 96 1 1 0",
               n, rec_er[0], rec_er[47], rec_er[48]);
    end
    checks++;
    if (rec_x1[0] != 270 || rec_x2[0] != 370 || rec_x1[48] != 280 || rec_y1[48] != 90 ||
        rec_x2[48] != 380 || rec_y2[48] != 90) begin
      errors++;
      $display("FAIL erase_geometry got old x %0d..%0d new (%0d,%0d)->(%0d,%0d) required old 270..370 new (280,90)->(380,90)",
               rec_x1[0], rec_x2[0], rec_x1[48], rec_y1[48], rec_x2[48], rec_y2[48]);
    end
  endtask

  task automatic test_clipping();
    int n;
    run_frame(20, 5, 200, 300, 440, 300, 0, 0, 0, -1, n);
    checks++;
    if (rec_x1[48] != 0 || rec_y1[48] != 0 || rec_x2[48] != 70 || rec_y2[48] != 0) begin
      errors++;
      $display("FAIL clip_low_seg0 got (%0d,%0d)->(%0d,%0d) required (0,0)->(70,0)",
               rec_x1[48], rec_y1[48], rec_x2[48], rec_y2[48]);
    end
    checks++;
    if (rec_y2[48+13] != 235) begin
      errors++;
      $display("FAIL clip_low_torso got y=%0d required 235", rec_y2[48+13]);
    end
    run_frame(630, 460, 200, 300, 440, 300, 0, 0, 0, -1, n);
    checks++;
    if (rec_x2[48] != 639 || rec_x1[48+13] != 639 || rec_y1[48+13] != 479 ||
        rec_x2[48+13] != 639 || rec_y2[48+13] != 479) begin
      errors++;
      $display("FAIL clip_high got seg0.x2=%0d torso (%0d,%0d)->(%0d,%0d) required 639 (639,479)->(639,479)",
               rec_x2[48], rec_x1[48+13], rec_y1[48+13], rec_x2[48+13], rec_y2[48+13]);
    end
  endtask

  task automatic test_backpressure();
    int n;
    run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
              1, 1, 1, -1, n);
    checks++;
    if (n != 96) begin
      errors++;
      $display("FAIL backpressure_count got %0d required 96", n);
    end
  endtask

  task automatic test_reset_midpass();
    int n;
    run_frame(300, 150, 100, 200, 500, 250, 0, 0, 0, 20, n);
    run_frame(310, 160, 110, 210, 510, 260, 0, 0, 0, -1, n);
    checks++;
    if (n != 48 || rec_er[0] != 0) begin
      errors++;
      $display("FAIL after_reset_no_erase got n=%0d er0=%0d required 48 0", n, rec_er[0]);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int f = 0; f < 3; f++) begin
      run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                f % 2, 0, 0, -1, n);
      checks++;
      if (n != 96) begin
        errors++;
        $display("FAIL back_to_back_count frame=%0d got %0d required 96", f, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_erase_pass();
    test_clipping();
    test_backpressure();
    test_reset_midpass();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
